// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into pulses with guaranteed minimum high and low widths.
// Optional `PULSE_STRETCH_RETRIGGER_EN: a strobe during the high phase extends the pulse instead of queueing.
module pulse_stretcher #(
    parameter int DIV        = 2,
    parameter int HIGH_TICKS = 8,
    parameter int LOW_TICKS  = 8,
    parameter int QDEPTH_W   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trigger,
    output logic                result,
    output logic                busy,
    output logic [QDEPTH_W-1:0] pending,
    output logic                overflow
);

    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX = (HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(DIV - 1);
    localparam logic [TW-1:0]       HIGH_LAST  = TW'(HIGH_TICKS - 1);
    localparam logic [TW-1:0]       LOW_LAST   = TW'(LOW_TICKS - 1);
    localparam logic [QDEPTH_W-1:0] PEND_MAX   = '1;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [QDEPTH_W-1:0] pend_q, pend_d;
    logic                result_q;
    logic                ovf_q, ovf_d;
    logic                tick, enq, deq;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    logic                rt_q, rt_d;
`endif

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        state_d = state_q;
        tcnt_d  = tcnt_q;
        deq     = 1'b0;
        enq     = trigger;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // Strobes in HIGH are remembered and restart the count on the next tick.
        rt_d = rt_q;
        if (state_q == HIGH) begin
            enq = 1'b0;
            if (trigger) rt_d = 1'b1;
        end
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (pend_q != '0) begin
                        state_d = HIGH;
                        tcnt_d  = '0;
                        deq     = 1'b1;
                    end
                end
                HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    if (rt_q || trigger) begin
                        tcnt_d = '0;
                        rt_d   = 1'b0;
                    end else
`endif
                    if (tcnt_q == HIGH_LAST) begin
                        state_d = GAP;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (tcnt_q == LOW_LAST) begin
                        tcnt_d = '0;
                        if (pend_q != '0) begin
                            state_d = HIGH;
                            deq     = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ovf_d  = 1'b0;
        pend_d = pend_q;
        if (enq && !deq) begin
            if (pend_q == PEND_MAX) ovf_d = 1'b1;
            else                    pend_d = pend_q + 1'b1;
        end else if (!enq && deq) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            tcnt_q   <= '0;
            pend_q   <= '0;
            result_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
            rt_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tcnt_q   <= tcnt_d;
            pend_q   <= pend_d;
            result_q <= (state_d == HIGH);
            ovf_q    <= ovf_d;
`ifdef PULSE_STRETCH_RETRIGGER_EN
            rt_q     <= rt_d;
`endif
        end
    end

    assign result   = result_q;
    assign busy     = (state_q != IDLE) || (pend_q != '0);
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher at DIV=2, HIGH_TICKS=8, LOW_TICKS=8, QDEPTH_W=2.
module tb_pulse_stretcher;
    localparam int DIV = 2;
    localparam int QW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trigger;
    logic          result, busy, overflow;
    logic [QW-1:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;
    int ovf_cnt = 0;
    int rises[$];
    int falls[$];
    int bfalls[$];
    int prise[$];
    logic prev_r = 1'b0;
    logic prev_b = 1'b0;

    pulse_stretcher #(.DIV(2), .HIGH_TICKS(8), .LOW_TICKS(8), .QDEPTH_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .result(result),
        .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge log of the outputs, sampled mid-cycle; cyc is the number of the last active edge.
    always @(negedge clk) begin
        if (result === 1'b1 && prev_r !== 1'b1) begin
            rises.push_back(cyc);
            prise.push_back(int'(pending));
        end
        if (result === 1'b0 && prev_r === 1'b1) falls.push_back(cyc);
        if (busy === 1'b0 && prev_b === 1'b1) bfalls.push_back(cyc);
        if (overflow === 1'b1) ovf_cnt++;
        prev_r = result;
        prev_b = busy;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        rises.delete(); falls.delete(); bfalls.delete(); prise.delete();
        ovf_cnt = 0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        trigger = 1'b0;
        repeat (3) step;
        rst_n = 1'b1;
        c0 = cyc;
        step;
        clear_log;
    endtask

    task automatic pulse_trig(input int n);
        trigger = 1'b1;
        repeat (n) step;
        trigger = 1'b0;
    endtask

    // Leaves the bench just after an edge such that the next edge is a tick edge.
    task automatic align_tick;
        while (((cyc - c0) % DIV) != DIV - 1) step;
    endtask

    task automatic wait_level(input logic lvl, input int budget, output bit ok);
        int n = 0;
        while (result !== lvl && n < budget) begin
            step;
            n++;
        end
        ok = (result === lvl);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        trigger = 1'b0;
        #3 rst_n = 1'b0;
        step;
        checks++; if (result !== 1'b0) begin errors++; $display("FAIL rst_result: got %b want 0", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (pending !== 2'd0) begin errors++; $display("FAIL rst_pending: got %0d want 0", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        pulse_trig(2);
        checks++; if (pending !== 2'd0) begin errors++; $display("FAIL rst_trig_ignored: got %0d want 0", pending); end
        rst_n = 1'b1;
        c0 = cyc;
        clear_log;
        repeat (10) step;
        checks++; if (rises.size() != 0) begin errors++; $display("FAIL rst_no_pulse: got %0d rises want 0", rises.size()); end
    endtask

    task automatic test_single;
        int tc;
        do_reset;
        tc = cyc + 1;
        pulse_trig(1);
        checks++; if (pending !== 2'd1) begin errors++; $display("FAIL t1_pending_after_strobe: got %0d want 1", pending); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_after_strobe: got %b want 1", busy); end
        repeat (60) step;
        checks++;
        if (rises.size() != 1 || falls.size() != 1 || bfalls.size() != 1) begin
            errors++;
            $display("FAIL t1_edge_count: got rises=%0d falls=%0d busy_falls=%0d want 1 1 1", rises.size(), falls.size(), bfalls.size());
        end else begin
            checks++; if (rises[0] - tc < 1 || rises[0] - tc > DIV) begin errors++; $display("FAIL t1_latency: got %0d want 1..%0d", rises[0] - tc, DIV); end
            checks++; if (falls[0] - rises[0] != 16) begin errors++; $display("FAIL t1_high_width: got %0d want 16", falls[0] - rises[0]); end
            checks++; if (bfalls[0] - falls[0] != 16) begin errors++; $display("FAIL t1_busy_tail: got %0d want 16", bfalls[0] - falls[0]); end
            checks++; if (prise[0] != 0) begin errors++; $display("FAIL t1_pending_at_start: got %0d want 0", prise[0]); end
        end
        checks++; if (busy !== 1'b0 || result !== 1'b0) begin errors++; $display("FAIL t1_idle_end: got busy=%b result=%b want 0 0", busy, result); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        align_tick;
        pulse_trig(3);
        repeat (120) step;
        checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL t2_overflow: got %0d cycles want 0", ovf_cnt); end
        checks++;
        if (rises.size() != 3 || falls.size() != 3) begin
            errors++;
            $display("FAIL t2_pulse_count: got rises=%0d falls=%0d want 3 3", rises.size(), falls.size());
        end else begin
            for (int p = 0; p < 3; p++) begin
                checks++; if (falls[p] - rises[p] != 16) begin errors++; $display("FAIL t2_high_%0d: got %0d want 16", p, falls[p] - rises[p]); end
                if (p < 2) begin
                    checks++; if (rises[p+1] - falls[p] != 16) begin errors++; $display("FAIL t2_low_%0d: got %0d want 16", p, rises[p+1] - falls[p]); end
                end
            end
            checks++; if (prise[2] != 0) begin errors++; $display("FAIL t2_pending_third: got %0d want 0", prise[2]); end
        end
    endtask

    task automatic test_overflow;
        bit ok;
        do_reset;
        pulse_trig(1);
        wait_level(1'b1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t3_first_rise: got result=%b want 1", result); end
`ifdef PULSE_STRETCH_RETRIGGER_EN
        wait_level(1'b0, 40, ok);
`endif
        pulse_trig(3);
        checks++; if (pending !== 2'd3 || overflow !== 1'b0) begin errors++; $display("FAIL t3_fill: got pending=%0d ovf=%b want 3 0", pending, overflow); end
        pulse_trig(1);
        checks++; if (pending !== 2'd3 || overflow !== 1'b1) begin errors++; $display("FAIL t3_drop: got pending=%0d ovf=%b want 3 1", pending, overflow); end
        step;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_ovf_one_cycle: got %b want 0", overflow); end
        repeat (200) step;
        checks++; if (rises.size() != 4) begin errors++; $display("FAIL t3_pulse_count: got %0d want 4", rises.size()); end
        checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL t3_ovf_total: got %0d want 1", ovf_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_pulse;
        do_reset;
        align_tick;
        pulse_trig(3);
        checks++; if (result !== 1'b1 || pending !== 2'd2) begin errors++; $display("FAIL t4_setup: got result=%b pending=%0d want 1 2", result, pending); end
        repeat (5) step;
        rst_n = 1'b0;
        #1;
        checks++; if (result !== 1'b0) begin errors++; $display("FAIL t4_result_drop: got %b want 0", result); end
        checks++; if (pending !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL t4_clear: got pending=%0d busy=%b want 0 0", pending, busy); end
        repeat (5) step;
        rst_n = 1'b1;
        c0 = cyc;
        clear_log;
        repeat (100) step;
        checks++; if (rises.size() != 0 || result !== 1'b0) begin errors++; $display("FAIL t4_no_pulse_after: got rises=%0d result=%b want 0 0", rises.size(), result); end
    endtask

    task automatic test_dequeue_collision;
        bit ok;
        do_reset;
        align_tick;
        pulse_trig(3);
        wait_level(1'b0, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t5_fall: got result=%b want 0", result); end
        pulse_trig(1);
        repeat (14) step;
        checks++; if (pending !== 2'd3 || result !== 1'b0) begin errors++; $display("FAIL t5_pre: got pending=%0d result=%b want 3 0", pending, result); end
        pulse_trig(1);
        checks++; if (result !== 1'b1) begin errors++; $display("FAIL t5_restart: got %b want 1", result); end
        checks++; if (pending !== 2'd3 || overflow !== 1'b0) begin errors++; $display("FAIL t5_collision: got pending=%0d ovf=%b want 3 0", pending, overflow); end
    endtask

    task automatic test_retrigger;
        bit ok;
        do_reset;
        pulse_trig(1);
        wait_level(1'b1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_rise: got result=%b want 1", result); end
        repeat (9) step;
        pulse_trig(1);
`ifdef PULSE_STRETCH_RETRIGGER_EN
        checks++; if (pending !== 2'd0) begin errors++; $display("FAIL t6_pending: got %0d want 0", pending); end
        repeat (150) step;
        checks++;
        if (rises.size() != 1 || falls.size() != 1) begin
            errors++;
            $display("FAIL t6_count: got rises=%0d falls=%0d want 1 1", rises.size(), falls.size());
        end else if (falls[0] - rises[0] < 26 || falls[0] - rises[0] > 28) begin
            errors++;
            $display("FAIL t6_extended_width: got %0d want 26..28", falls[0] - rises[0]);
        end
`else
        checks++; if (pending !== 2'd1) begin errors++; $display("FAIL t6_pending: got %0d want 1", pending); end
        repeat (150) step;
        checks++;
        if (rises.size() != 2 || falls.size() != 2) begin
            errors++;
            $display("FAIL t6_count: got rises=%0d falls=%0d want 2 2", rises.size(), falls.size());
        end else begin
            checks++; if (falls[0] - rises[0] != 16) begin errors++; $display("FAIL t6_first_width: got %0d want 16", falls[0] - rises[0]); end
            checks++; if (rises[1] - falls[0] != 16) begin errors++; $display("FAIL t6_gap: got %0d want 16", rises[1] - falls[0]); end
            checks++; if (falls[1] - rises[1] != 16) begin errors++; $display("FAIL t6_second_width: got %0d want 16", falls[1] - rises[1]); end
        end
`endif
    endtask

    initial begin
        trigger = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_reset_mid_pulse;
        test_dequeue_collision;
        test_retrigger;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
